// File: rtl/ss_rvc_lsu.sv
// ---------------------------------------------------------------------------
// ss_rvc_lsu -- single-outstanding load/store unit for an RV32 core.
//
// Accepts one request at a time, checks it against the data-memory window
// and the funct3 encoding, then performs a single word access on a simple
// SRAM-style port with a fixed read latency. Each request produces exactly
// one single-cycle response pulse, with the load result or an error flag.
//
// Parameters:
//   XLEN         data/address width (only 32 supported)
//   MSB_D_MEM    data-memory MSB; memory holds 2**(MSB_D_MEM+1) bytes
//   D_MEM_OFFSET byte base address of the data memory window
//   RD_LATENCY   cycles from MemEn to valid MemRdData (1..4)
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   ReqValid/ReqReady         request handshake (ready only when idle)
//   ReqOp                     0 = load, 1 = store
//   ReqFunct3                 RV32 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ReqAddr, ReqWrData        byte address, right-aligned store data
//   RspValid, RspData, RspErr one-cycle response, load result, reject flag
//   MemEn, MemWrEn            memory strobe and write strobe
//   MemByteEn, MemAddr        byte lanes and word index
//   MemWrData, MemRdData      lane-aligned store data, read word
//
// Build option:
//   SS_RVC_LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word
//   accesses are rejected; otherwise they are aligned down and performed.
// ---------------------------------------------------------------------------
module ss_rvc_lsu #(
    parameter int XLEN         = 32,
    parameter int MSB_D_MEM    = 9,
    parameter int D_MEM_OFFSET = 1024,
    parameter int RD_LATENCY   = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqOp,
    input  logic [2:0]           ReqFunct3,
    input  logic [XLEN-1:0]      ReqAddr,
    input  logic [XLEN-1:0]      ReqWrData,
    output logic                 RspValid,
    output logic [XLEN-1:0]      RspData,
    output logic                 RspErr,
    output logic                 MemEn,
    output logic                 MemWrEn,
    output logic [3:0]           MemByteEn,
    output logic [MSB_D_MEM-2:0] MemAddr,
    output logic [XLEN-1:0]      MemWrData,
    input  logic [XLEN-1:0]      MemRdData
);

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [XLEN-1:0] MEM_BASE = XLEN'(D_MEM_OFFSET);
    localparam logic [XLEN-1:0] MEM_SPAN = XLEN'((2 ** (MSB_D_MEM + 1)) - 1);
    localparam logic [1:0]      LAT_M1   = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic [1:0] lat_cnt;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic funct3_legal(input logic op, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return (op == OP_RD);
            default:                return 1'b0;
        endcase
    endfunction

    // Byte lane the access starts at; halfwords and words are aligned down.
    function automatic logic [1:0] lane_align(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [XLEN-1:0] wd, input logic [1:0] lane);
        return wd << {lane, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0]      lane,
                                                     input logic [2:0]      f3);
        logic [XLEN-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  return {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Request decode (combinational on the request inputs)
    // -----------------------------------------------------------------------
    logic [XLEN-1:0]      req_off;
    logic                 req_in_range;
    logic                 req_misalign;
    logic                 req_bad;
    logic [MSB_D_MEM-2:0] req_widx;
    logic                 accept;

    assign req_off      = ReqAddr - MEM_BASE;
    // The lower-bound test guards against the subtraction wrapping around.
    assign req_in_range = (ReqAddr >= MEM_BASE) && (req_off <= MEM_SPAN);
    assign req_widx     = req_off[MSB_D_MEM:2];

`ifdef SS_RVC_LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0]) ||
                          ((ReqFunct3 == 3'b010) && (ReqAddr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_bad = !funct3_legal(ReqOp, ReqFunct3) || !req_in_range || req_misalign;
    assign accept  = ReqValid && ReqReady;

    // -----------------------------------------------------------------------
    // Registered request fields and captured read data
    // -----------------------------------------------------------------------
    logic                 op_p0;
    logic [2:0]           f3_p0;
    logic [1:0]           lane_p0;
    logic [MSB_D_MEM-2:0] widx_p0;
    logic [XLEN-1:0]      wdata_p0;
    logic                 err_p0;
    logic [XLEN-1:0]      rdata_p1;

    always_ff @(posedge Clk) begin
        if (accept) begin
            op_p0    <= ReqOp;
            f3_p0    <= ReqFunct3;
            lane_p0  <= lane_align(ReqFunct3, ReqAddr[1:0]);
            widx_p0  <= req_widx;
            wdata_p0 <= ReqWrData;
            err_p0   <= req_bad;
        end
        // Last WAIT cycle is exactly RD_LATENCY cycles after ISSUE.
        if (state == WAIT && lat_cnt == 2'd0) begin
            rdata_p1 <= load_extract(MemRdData, lane_p0, f3_p0);
        end
    end

    // -----------------------------------------------------------------------
    // State register and latency down-counter
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state <= state_next;
            if (state == ISSUE) begin
                lat_cnt <= LAT_M1;
            end else if (state == WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs; every output is forced low while Rst is high
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ReqReady   = 1'b0;
        RspValid   = 1'b0;
        RspData    = '0;
        RspErr     = 1'b0;
        MemEn      = 1'b0;
        MemWrEn    = 1'b0;
        MemByteEn  = 4'b0000;
        MemAddr    = '0;
        MemWrData  = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_next = (op_p0 == OP_WR) ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!Rst) begin
            case (state)
                IDLE: begin
                    ReqReady = 1'b1;
                end
                ISSUE: begin
                    MemEn   = 1'b1;
                    MemAddr = widx_p0;
                    if (op_p0 == OP_WR) begin
                        MemWrEn   = 1'b1;
                        MemByteEn = store_be(f3_p0, lane_p0);
                        MemWrData = store_data(wdata_p0, lane_p0);
                    end else begin
                        MemByteEn = 4'b1111;
                    end
                end
                RESP: begin
                    RspValid = 1'b1;
                    RspErr   = err_p0;
                    // Errors and stores return zero data.
                    if (!err_p0 && op_p0 == OP_RD) begin
                        RspData = rdata_p1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ss_rvc_lsu.sv
// ---------------------------------------------------------------------------
// Bench for ss_rvc_lsu with RD_LATENCY=2. A transaction-level model predicts
// every output on every cycle; directed requests with literal expectations
// pin the model to the documented examples.
// ---------------------------------------------------------------------------
module tb_ss_rvc_lsu;

    localparam int L    = 2;
    localparam int BASE = 1024;
    localparam int SIZE = 1024;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqOp = 1'b0;
    logic [2:0]  ReqFunct3 = 3'b000;
    logic [31:0] ReqAddr = 32'h0;
    logic [31:0] ReqWrData = 32'h0;
    logic        RspValid;
    logic [31:0] RspData;
    logic        RspErr;
    logic        MemEn;
    logic        MemWrEn;
    logic [3:0]  MemByteEn;
    logic [7:0]  MemAddr;
    logic [31:0] MemWrData;
    logic [31:0] MemRdData;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ss_rvc_lsu #(
        .XLEN(32), .MSB_D_MEM(9), .D_MEM_OFFSET(BASE), .RD_LATENCY(L)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWrData(ReqWrData),
        .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
        .MemEn(MemEn), .MemWrEn(MemWrEn), .MemByteEn(MemByteEn),
        .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRdData(MemRdData)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] pattern(input int i);
        if (i == 1) return 32'h8000_0000;
        return 32'(i) * 32'h01F3_2D17 + 32'h9A3C_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------- memory with fixed read latency --------------------
    logic [31:0] env_mem [256];
    logic [31:0] rd_pipe [L];
    bit          env_init = 1'b0;

    assign MemRdData = rd_pipe[L-1];

    always @(posedge Clk) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= pattern(i);
            env_init <= 1'b1;
        end else if (MemEn && MemWrEn) begin
            env_mem[MemAddr] <= merge(env_mem[MemAddr], MemWrData, MemByteEn);
        end
        // Junk when no read was issued, so a mistimed sample is visible.
        rd_pipe[0] <= (MemEn && !MemWrEn) ? env_mem[MemAddr] : (32'hA5A5_5A5A ^ 32'(cyc));
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    // -------------------- transaction-level model --------------------
    logic [31:0] ref_mem [256];
    bit          ref_init = 1'b0;
    bit          m_busy = 1'b0;
    int          m_acc, m_len;
    bit          m_err, m_wr;
    logic [3:0]  m_be;
    logic [7:0]  m_widx;
    logic [31:0] m_wdata, m_rdata;

    task automatic model_accept(input logic op, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        longint a, ea, v, lane, sz;
        bit legal, sgn;
        a = longint'(addr);
        sgn = 1'b0;
        case (f3)
            3'd0: begin sz = 1; legal = 1; sgn = 1; end
            3'd1: begin sz = 2; legal = 1; sgn = 1; end
            3'd2: begin sz = 4; legal = 1; end
            3'd4: begin sz = 1; legal = !op; end
            3'd5: begin sz = 2; legal = !op; end
            default: begin sz = 4; legal = 0; end
        endcase
        m_err = !legal || a < BASE || a > BASE + SIZE - 1;
`ifdef SS_RVC_LSU_MISALIGN_TRAP_EN
        if (legal && (a % sz) != 0) m_err = 1'b1;
`endif
        m_wr   = op;
        ea     = a - (a % sz);
        lane   = ea % 4;
        m_widx = 8'(((a - BASE) / 4) % 256);
        m_len  = m_err ? 1 : (op ? 2 : 2 + L);
        if (!m_err && op) begin
            m_be    = 4'(((1 << sz) - 1) << lane);
            m_wdata = 32'((longint'(wd) << (8 * lane)) & 64'hFFFF_FFFF);
            for (int i = 0; i < sz; i++)
                ref_mem[m_widx][8*(lane+i) +: 8] = wd[8*i +: 8];
        end
        if (!m_err && !op) begin
            v = (longint'(ref_mem[m_widx]) >> (8 * lane)) & ((64'd1 << (8 * sz)) - 1);
            if (sgn && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
            m_rdata = 32'(v);
        end
    endtask

    always @(negedge Clk) begin : model
        bit e_ready, e_men, e_we, e_rv, e_err;
        logic [3:0]  e_be;
        logic [31:0] e_data;
        int k;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
            ref_init = 1'b1;
        end
        e_ready = !Rst && !m_busy;
        e_men = 0; e_we = 0; e_rv = 0; e_err = 0; e_be = 4'h0; e_data = 32'h0;
        k = cyc - m_acc;
        if (!Rst && m_busy) begin
            if (k == 1 && !m_err) begin
                e_men = 1; e_we = m_wr; e_be = m_wr ? m_be : 4'hF;
            end
            if (k == m_len) begin
                e_rv = 1; e_err = m_err; e_data = m_err ? 32'h0 : m_rdata;
            end
        end
        chk("m_ReqReady", 32'(ReqReady), 32'(e_ready));
        chk("m_MemEn", 32'(MemEn), 32'(e_men));
        chk("m_MemWrEn", 32'(MemWrEn), 32'(e_we));
        chk("m_MemByteEn", 32'(MemByteEn), 32'(e_be));
        chk("m_RspValid", 32'(RspValid), 32'(e_rv));
        chk("m_RspErr", 32'(RspErr), 32'(e_err));
        if (e_men) chk("m_MemAddr", 32'(MemAddr), 32'(m_widx));
        if (e_we)  chk("m_MemWrData", MemWrData, m_wdata);
        if (!(e_rv && m_wr && !m_err)) chk("m_RspData", RspData, e_data);
        if (Rst) m_busy = 0;
        else if (m_busy) begin
            if (k == m_len) m_busy = 0;
        end else if (ReqValid) begin
            model_accept(ReqOp, ReqFunct3, ReqAddr, ReqWrData);
            m_acc  = cyc;
            m_busy = 1;
        end
    end

    // -------------------- stimulus --------------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int tries;
        bit done;
        tries = 0;
        done  = 0;
        ReqOp = op; ReqFunct3 = f3; ReqAddr = a; ReqWrData = wd; ReqValid = 1'b1;
        while (!done) begin
            @(negedge Clk);
            if (ReqReady) done = 1;
            else if (tries >= 20) begin
                n_cmp++; n_bad++;
                $display("FAIL req_accept: ReqReady stayed 0 for %0d cycles, required 1", tries);
                done = 1;
            end
            tries++;
            @(posedge Clk); #1;
        end
        ReqValid = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge Clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("rst_ready", 32'(ReqReady), 32'h0);
        chk("rst_rspvalid", 32'(RspValid), 32'h0);
        chk("rst_memen", 32'(MemEn), 32'h0);
        next_edge();
        Rst = 1'b0;
        @(negedge Clk);
        chk("ready_after_rst", 32'(ReqReady), 32'h1);
        next_edge();

        // LB / LBU at 0x407, word = 0x80000000
        send(1'b0, 3'b000, 32'h407, 32'h0);
        repeat (4) @(negedge Clk);
        chk("lb_rspvalid", 32'(RspValid), 32'h1);
        chk("lb_data", RspData, 32'hFFFF_FF80);
        next_edge();
        send(1'b0, 3'b100, 32'h407, 32'h0);
        repeat (4) @(negedge Clk);
        chk("lbu_data", RspData, 32'h0000_0080);
        next_edge();

        // SW 0xDEADBEEF at 0x404
        send(1'b1, 3'b010, 32'h404, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("sw_memen", 32'(MemEn), 32'h1);
        chk("sw_wren", 32'(MemWrEn), 32'h1);
        chk("sw_addr", 32'(MemAddr), 32'h1);
        chk("sw_be", 32'(MemByteEn), 32'hF);
        chk("sw_wdata", MemWrData, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("sw_rspvalid", 32'(RspValid), 32'h1);
        chk("sw_rsperr", 32'(RspErr), 32'h0);
        next_edge();

        // SH 0x1234 at 0x402
        send(1'b1, 3'b001, 32'h402, 32'h0000_1234);
        @(negedge Clk);
        chk("sh_be", 32'(MemByteEn), 32'hC);
        chk("sh_wdata", MemWrData, 32'h1234_0000);
        chk("sh_addr", 32'(MemAddr), 32'h0);
        next_edge();

        // Rejections
        send(1'b0, 3'b010, 32'h3FC, 32'h0);
        @(negedge Clk);
        chk("oor_rspvalid", 32'(RspValid), 32'h1);
        chk("oor_rsperr", 32'(RspErr), 32'h1);
        chk("oor_data", RspData, 32'h0);
        chk("oor_memen", 32'(MemEn), 32'h0);
        next_edge();
        send(1'b1, 3'b100, 32'h404, 32'h1111_2222);
        @(negedge Clk);
        chk("ill_rsperr", 32'(RspErr), 32'h1);
        chk("ill_memen", 32'(MemEn), 32'h0);
        next_edge();

        // Misaligned LW at 0x405
        send(1'b0, 3'b010, 32'h405, 32'h0);
        @(negedge Clk);
`ifdef SS_RVC_LSU_MISALIGN_TRAP_EN
        chk("mis_rsperr", 32'(RspErr), 32'h1);
`else
        chk("mis_addr", 32'(MemAddr), 32'h1);
        repeat (3) @(negedge Clk);
        chk("mis_data", RspData, 32'hDEAD_BEEF);
`endif
        next_edge();

        // Reset while waiting for read data
        send(1'b0, 3'b010, 32'h408, 32'h0);
        next_edge();
        Rst = 1'b1;
        next_edge();
        next_edge();
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_ready", 32'(ReqReady), 32'h1);
        chk("abort_rspvalid", 32'(RspValid), 32'h0);
        next_edge();
        send(1'b1, 3'b010, 32'h404, 32'h0BAD_F00D);
        @(negedge Clk);
        chk("sw2_memen", 32'(MemEn), 32'h1);
        chk("sw2_wdata", MemWrData, 32'h0BAD_F00D);
        @(negedge Clk);
        chk("sw2_rspvalid", 32'(RspValid), 32'h1);
        next_edge();

        // Mixed traffic, checked by the model
        send(1'b0, 3'b001, 32'h406, 32'h0);
        send(1'b0, 3'b101, 32'h406, 32'h0);
        send(1'b0, 3'b001, 32'h401, 32'h0);
        for (int i = 0; i < 4; i++) send(1'b0, 3'b000, 32'h400 + 32'(i), 32'h0);
        send(1'b0, 3'b100, 32'h7FF, 32'h0);
        send(1'b0, 3'b010, 32'h800, 32'h0);
        send(1'b0, 3'b010, 32'h7FC, 32'h0);
        send(1'b1, 3'b000, 32'h40B, 32'h0000_00AB);
        send(1'b0, 3'b000, 32'h40B, 32'h0);
        send(1'b1, 3'b001, 32'h40D, 32'hFFFF_8765);
        send(1'b0, 3'b010, 32'h40C, 32'h0);
        send(1'b1, 3'b101, 32'h410, 32'h5555_5555);
        send(1'b0, 3'b011, 32'h410, 32'h0);
        send(1'b0, 3'b110, 32'h410, 32'h0);
        send(1'b0, 3'b111, 32'h410, 32'h0);
        send(1'b1, 3'b010, 32'h7FC, 32'hCAFE_F00D);
        send(1'b0, 3'b010, 32'h7FC, 32'h0);
        send(1'b0, 3'b101, 32'h7FE, 32'h0);
        send(1'b0, 3'b001, 32'h7FE, 32'h0);
        send(1'b1, 3'b000, 32'h3FF, 32'h0000_0077);
        send(1'b0, 3'b100, 32'h400, 32'h0);
        repeat (8) next_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
